// File: rtl/dcm_rst_ctrl_pkg.sv
// Shared definitions for the DCM reset/lock sequencer: state encoding,
// default timing parameters and an elaboration-time sizing helper.
package dcm_rst_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  localparam int DEF_RST_PULSE_CYCLES = 8;
  localparam int DEF_LOCK_TIMEOUT     = 4096;
  localparam int DEF_LOCK_STABLE      = 256;
  localparam int DEF_RETRY_LIMIT      = 15;

  localparam logic [3:0] RETRY_SAT = 4'd15;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dcm_rst_ctrl_if.sv
// Status/control bundle between the sequencer (master) and the DCM plus
// downstream reset consumers (slave).
interface dcm_rst_ctrl_if;
  logic       locked;
  logic       clkfx_stopped;
  logic       dcm_reset;
  logic       sys_reset;
  logic       lock_ok;
  logic [3:0] retry_cnt;
  logic       fail;

  modport master (
    input  locked, clkfx_stopped,
    output dcm_reset, sys_reset, lock_ok, retry_cnt, fail
  );

  modport slave (
    output locked, clkfx_stopped,
    input  dcm_reset, sys_reset, lock_ok, retry_cnt, fail
  );
endinterface

// File: rtl/dcm_rst_ctrl_sync_2ff.sv
// 1-bit two-flop synchronizer for DCM status pins that are asynchronous to clk_in.
module sync_2ff (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; both stages clear on reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dcm_rst_ctrl.sv
// DCM reset pulse / lock supervision sequencer with bounded retries; releases
// the downstream sys_reset only after lock has been stable for LOCK_STABLE cycles.
module dcm_rst_ctrl
  import dcm_rst_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE      = DEF_LOCK_STABLE,
  parameter int RETRY_LIMIT      = DEF_RETRY_LIMIT
) (
  input logic            clk_in,
  input logic            reset,
  dcm_rst_ctrl_if.master bus
);

  localparam int CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [4:0]       LIMIT    = 5'(RETRY_LIMIT);

  logic             locked_s;
  logic             stop_s;
  logic             fail_evt_s;
  logic [4:0]       retry_inc_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             dcm_reset_q, dcm_reset_d;
  logic             sys_reset_q, sys_reset_d;
  logic             lock_ok_q, lock_ok_d;
  logic             fail_q, fail_d;

  sync_2ff u_sync_locked (.clk_in(clk_in), .reset(reset), .d(bus.locked),        .q(locked_s));
  sync_2ff u_sync_stop   (.clk_in(clk_in), .reset(reset), .d(bus.clkfx_stopped), .q(stop_s));

  // Next-state, counter, retry and output decode.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    fail_evt_s  = 1'b0;
    retry_inc_s = {1'b0, retry_q} + 5'd1;

    case (state_q)
      ST_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT;
        else                   state_d = ST_RST;
      end
      ST_WAIT: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s)              state_d = ST_STABLE;
        else if (cnt_q == TO_LAST) fail_evt_s = 1'b1;
        else                       state_d = ST_WAIT;
      end
      ST_STABLE: begin
        if (!locked_s || stop_s) begin
          state_d = ST_WAIT;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
          retry_d = 4'd0;
        end else begin
          state_d = ST_STABLE;
        end
      end
      ST_RUN: begin
        if (!locked_s || stop_s) fail_evt_s = 1'b1;
        else                     state_d = ST_RUN;
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_RST;
    endcase

    if (fail_evt_s) begin
      if ((RETRY_LIMIT != 0) && (retry_inc_s >= LIMIT)) begin
        state_d = ST_FAIL;
        retry_d = LIMIT[3:0];
      end else begin
        state_d = ST_RST;
        retry_d = (retry_q == RETRY_SAT) ? RETRY_SAT : retry_inc_s[3:0];
      end
    end else begin
      retry_d = retry_d;
    end

    if (state_d != state_q)                          cnt_d = CNT_ZERO;
    else if (state_q == ST_RUN || state_q == ST_FAIL) cnt_d = cnt_q;
    else                                             cnt_d = cnt_q + CNT_ONE;

    // Outputs are decoded from the next state so they change on the same edge as the state.
    dcm_reset_d = (state_d == ST_RST) || (state_d == ST_FAIL);
    sys_reset_d = (state_d != ST_RUN);
    lock_ok_d   = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= ST_RST;
      cnt_q       <= CNT_ZERO;
      retry_q     <= 4'd0;
      dcm_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      lock_ok_q   <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      dcm_reset_q <= dcm_reset_d;
      sys_reset_q <= sys_reset_d;
      lock_ok_q   <= lock_ok_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.dcm_reset = dcm_reset_q;
  assign bus.sys_reset = sys_reset_q;
  assign bus.lock_ok   = lock_ok_q;
  assign bus.retry_cnt = retry_q;
  assign bus.fail      = fail_q;

endmodule

// File: tb/tb_dcm_rst_ctrl.sv
// Bench for dcm_rst_ctrl: two instances (retry limit 3 and unlimited) share stimulus
// and are compared against a dwell-time reference model every cycle.
module tb_dcm_rst_ctrl;

  localparam int RSTP = 4;
  localparam int TO   = 32;
  localparam int LS   = 8;

  localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FAIL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic locked = 1'b0;
  logic clkfx_stopped = 1'b0;

  dcm_rst_ctrl_if ifa();
  dcm_rst_ctrl_if ifb();
  assign ifa.locked = locked;
  assign ifa.clkfx_stopped = clkfx_stopped;
  assign ifb.locked = locked;
  assign ifb.clkfx_stopped = clkfx_stopped;

  dcm_rst_ctrl #(.RST_PULSE_CYCLES(RSTP), .LOCK_TIMEOUT(TO), .LOCK_STABLE(LS), .RETRY_LIMIT(3))
    dut_a (.clk_in(clk), .reset(reset), .bus(ifa));
  dcm_rst_ctrl #(.RST_PULSE_CYCLES(RSTP), .LOCK_TIMEOUT(TO), .LOCK_STABLE(LS), .RETRY_LIMIT(0))
    dut_b (.clk_in(clk), .reset(reset), .bus(ifb));

  wire [7:0] obs_a = {ifa.dcm_reset, ifa.sys_reset, ifa.lock_ok, ifa.fail, ifa.retry_cnt};
  wire [7:0] obs_b = {ifb.dcm_reset, ifb.sys_reset, ifb.lock_ok, ifb.fail, ifb.retry_cnt};

  int passed = 0;
  int total  = 0;

  // Reference model: phase plus the cycle it was entered; transitions fire after fixed dwell times.
  int m_ph[2];
  int m_ent[2];
  int m_rc[2];
  int lim[2] = '{3, 0};
  int cyc = 0;
  bit h1l = 1'b0, h2l = 1'b0, h1s = 1'b0, h2s = 1'b0;

  function automatic logic [7:0] exp_vec(input int i);
    logic [3:0] rc;
    rc = 4'(m_rc[i]);
    return {(m_ph[i] == M_RST) || (m_ph[i] == M_FAIL), m_ph[i] != M_RUN,
            m_ph[i] == M_RUN, m_ph[i] == M_FAIL, rc};
  endfunction

  task automatic m_failure(input int i);
    if (lim[i] != 0 && m_rc[i] + 1 >= lim[i]) begin
      m_ph[i] = M_FAIL;
      m_rc[i] = lim[i];
    end else begin
      m_rc[i] = (m_rc[i] + 1 > 15) ? 15 : m_rc[i] + 1;
      m_ph[i] = M_RST;
    end
    m_ent[i] = cyc;
  endtask

  task automatic m_edge(input int i, input bit lk, input bit st);
    int dwell;
    dwell = cyc - m_ent[i];
    case (m_ph[i])
      M_RST:  if (dwell == RSTP) begin m_ph[i] = M_WAIT; m_ent[i] = cyc; end
      M_WAIT: begin
        if (lk) begin m_ph[i] = M_STAB; m_ent[i] = cyc; end
        else if (dwell == TO) m_failure(i);
      end
      M_STAB: begin
        if (!lk || st) begin m_ph[i] = M_WAIT; m_ent[i] = cyc; end
        else if (dwell == LS) begin m_ph[i] = M_RUN; m_ent[i] = cyc; m_rc[i] = 0; end
      end
      M_RUN:  if (!lk || st) m_failure(i);
      default: ;
    endcase
  endtask

  // Advance one clock: update the model with what the DUT sees at this edge, then settle.
  task automatic tick();
    bit ul, us;
    @(posedge clk);
    cyc++;
    ul = h2l; us = h2s;
    h2l = h1l; h1l = locked;
    h2s = h1s; h1s = clkfx_stopped;
    if (reset) begin
      h1l = 1'b0; h2l = 1'b0; h1s = 1'b0; h2s = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_ph[i] = M_RST; m_ent[i] = cyc; m_rc[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) m_edge(i, ul, us);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; locked = 1'b0; clkfx_stopped = 1'b0;
    tick(); tick();
    total++;
    if (obs_a !== 8'b1100_0000) $display("FAIL reset_a got=%b exp=%b", obs_a, 8'b1100_0000);
    else passed++;
    total++;
    if (obs_b !== 8'b1100_0000) $display("FAIL reset_b got=%b exp=%b", obs_b, 8'b1100_0000);
    else passed++;
  endtask

  task automatic test_clean_lock(input int delay);
    int n, lat;
    reset = 1'b1; locked = 1'b0; tick(); reset = 1'b0;
    n = 1;
    for (int k = 0; k < 20 && obs_a[7]; k++) begin
      tick();
      total++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)})
        $display("FAIL clean_model cyc=%0d got=%b/%b exp=%b/%b", cyc, obs_a, obs_b, exp_vec(0), exp_vec(1));
      else passed++;
      if (obs_a[7]) n++;
    end
    total++;
    if (n !== RSTP) $display("FAIL dcm_pulse_len got=%0d exp=%0d", n, RSTP);
    else passed++;
    repeat (delay) tick();
    locked = 1'b1;
    lat = 0;
    for (int k = 0; k < 40 && obs_a[6]; k++) begin
      tick(); lat++;
      total++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)})
        $display("FAIL clean_model cyc=%0d got=%b/%b exp=%b/%b", cyc, obs_a, obs_b, exp_vec(0), exp_vec(1));
      else passed++;
    end
    total++;
    if (lat !== 3 + LS) $display("FAIL sys_reset_latency got=%0d exp=%0d", lat, 3 + LS);
    else passed++;
    total++;
    if (obs_a !== 8'b0010_0000) $display("FAIL run_outputs got=%b exp=%b", obs_a, 8'b0010_0000);
    else passed++;
  endtask

  task automatic test_timeout();
    int t1, t2, tf;
    t1 = -1; t2 = -1; tf = -1;
    reset = 1'b1; locked = 1'b0; tick(); reset = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      tick();
      total++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)})
        $display("FAIL timeout_model cyc=%0d got=%b/%b exp=%b/%b", cyc, obs_a, obs_b, exp_vec(0), exp_vec(1));
      else passed++;
      if (t1 < 0 && obs_a[3:0] == 4'd1) t1 = k;
      if (t2 < 0 && obs_a[3:0] == 4'd2) t2 = k;
      if (tf < 0 && obs_a[4]) tf = k;
    end
    total++;
    if (t1 !== RSTP + TO) $display("FAIL timeout_1 got=%0d exp=%0d", t1, RSTP + TO);
    else passed++;
    total++;
    if (t2 !== 2 * (RSTP + TO)) $display("FAIL timeout_2 got=%0d exp=%0d", t2, 2 * (RSTP + TO));
    else passed++;
    total++;
    if (tf !== 3 * (RSTP + TO)) $display("FAIL timeout_fail got=%0d exp=%0d", tf, 3 * (RSTP + TO));
    else passed++;
    total++;
    if (obs_a !== 8'b1101_0011) $display("FAIL fail_outputs got=%b exp=%b", obs_a, 8'b1101_0011);
    else passed++;
  endtask

  task automatic test_timeout_vs_lock();
    reset = 1'b1; locked = 1'b0; tick(); reset = 1'b0;
    repeat (RSTP + TO - 3) tick();
    locked = 1'b1;
    for (int k = 0; k < 4 + LS; k++) begin
      tick();
      total++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)})
        $display("FAIL tie_model cyc=%0d got=%b/%b exp=%b/%b", cyc, obs_a, obs_b, exp_vec(0), exp_vec(1));
      else passed++;
    end
    total++;
    if (obs_a !== 8'b0010_0000) $display("FAIL tie_lock_wins got=%b exp=%b", obs_a, 8'b0010_0000);
    else passed++;
  endtask

  task automatic test_glitch(input int p);
    int lat;
    reset = 1'b1; locked = 1'b1; tick(); reset = 1'b0;
    repeat (RSTP + 1 + p) tick();
    locked = 1'b0; tick(); tick(); locked = 1'b1;
    lat = 0;
    for (int k = 0; k < 40 && obs_a[6]; k++) begin
      tick(); lat++;
      total++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)})
        $display("FAIL glitch_model p=%0d cyc=%0d got=%b/%b exp=%b/%b", p, cyc, obs_a, obs_b, exp_vec(0), exp_vec(1));
      else passed++;
      if (obs_a[3:0] !== 4'd0) $display("FAIL glitch_retry p=%0d got=%0d exp=0", p, obs_a[3:0]);
    end
    total++;
    if (lat !== 3 + LS) $display("FAIL glitch_restart p=%0d got=%0d exp=%0d", p, lat, 3 + LS);
    else passed++;
  endtask

  task automatic test_run_loss(input int kind);
    int lat, n;
    reset = 1'b1; locked = 1'b1; clkfx_stopped = 1'b0; tick(); reset = 1'b0;
    n = 0;
    while (n < 40 && !obs_a[5]) begin tick(); n++; end
    total++;
    if (obs_a[5] !== 1'b1) $display("FAIL loss_reach_run kind=%0d got=%b exp=1", kind, obs_a[5]);
    else passed++;
    repeat ($urandom_range(0, 5)) tick();
    if (kind == 0) locked = 1'b0;
    else clkfx_stopped = 1'b1;
    lat = 0;
    for (int k = 0; k < 10 && !obs_a[6]; k++) begin
      tick(); lat++;
      clkfx_stopped = 1'b0;
      total++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)})
        $display("FAIL loss_model kind=%0d cyc=%0d got=%b/%b exp=%b/%b", kind, cyc, obs_a, obs_b, exp_vec(0), exp_vec(1));
      else passed++;
    end
    total++;
    if (lat !== 3) $display("FAIL loss_latency kind=%0d got=%0d exp=3", kind, lat);
    else passed++;
    total++;
    if (obs_a !== 8'b1100_0001) $display("FAIL loss_outputs kind=%0d got=%b exp=%b", kind, obs_a, 8'b1100_0001);
    else passed++;
    repeat (2) tick();
    locked = 1'b1;
    n = 0;
    while (n < 60 && !obs_a[5]) begin
      tick(); n++;
      total++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)})
        $display("FAIL relock_model kind=%0d cyc=%0d got=%b/%b exp=%b/%b", kind, cyc, obs_a, obs_b, exp_vec(0), exp_vec(1));
      else passed++;
    end
    total++;
    if (obs_a !== 8'b0010_0000) $display("FAIL relock_clear kind=%0d got=%b exp=%b", kind, obs_a, 8'b0010_0000);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    reset = 1'b1; locked = 1'b1; tick(); reset = 1'b0;
    repeat (RSTP + 3) tick();
    reset = 1'b1; tick();
    total++;
    if ({obs_a, obs_b} !== {8'b1100_0000, 8'b1100_0000})
      $display("FAIL reset_in_stable got=%b/%b exp=11000000", obs_a, obs_b);
    else passed++;
    reset = 1'b0; locked = 1'b0;
    n = 0;
    while (n < 200 && !obs_a[4]) begin tick(); n++; end
    total++;
    if (obs_a[4] !== 1'b1) $display("FAIL reach_fail got=%b exp=1", obs_a[4]);
    else passed++;
    reset = 1'b1; tick();
    total++;
    if ({obs_a, obs_b} !== {8'b1100_0000, 8'b1100_0000})
      $display("FAIL reset_in_fail got=%b/%b exp=11000000", obs_a, obs_b);
    else passed++;
  endtask

  task automatic test_unlimited();
    bit saw_fail;
    saw_fail = 1'b0;
    reset = 1'b1; locked = 1'b0; tick(); reset = 1'b0;
    for (int k = 1; k <= 20 * (RSTP + TO); k++) begin
      tick();
      if (obs_b[4]) saw_fail = 1'b1;
      total++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)})
        $display("FAIL unlim_model cyc=%0d got=%b/%b exp=%b/%b", cyc, obs_a, obs_b, exp_vec(0), exp_vec(1));
      else passed++;
    end
    total++;
    if (saw_fail !== 1'b0) $display("FAIL unlim_no_fail got=%b exp=0", saw_fail);
    else passed++;
    total++;
    if (obs_b !== 8'b1100_1111) $display("FAIL unlim_saturate got=%b exp=%b", obs_b, 8'b1100_1111);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_clean_lock(10);
    test_clean_lock($urandom_range(0, 25));
    test_timeout();
    test_timeout_vs_lock();
    test_glitch(5);
    test_glitch($urandom_range(0, 5));
    test_run_loss(0);
    test_run_loss(1);
    test_run_loss($urandom_range(0, 1));
    test_reset_mid();
    test_unlimited();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
